muldiv_unit: RTL and testbench

Iterative, parametrised RV32M/RV64M multiply-divide unit that sits beside the single-cycle `alu` in the execute stage. It accepts one operation at a time through a start/done handshake, computes it over XLEN iterations, and returns a registered result. It covers all eight M-extension operations, including the architecturally defined divide-by-zero and signed-overflow results. It also supports pipeline flush.

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiply-divide unit.
// The master drives requests and flush; the slave returns status and the registered result.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            flush;
    logic            ready;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, operand1, operand2, flush,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, op, operand1, operand2, flush,
        output ready, busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply-divide unit: one bit per cycle, sign-magnitude datapath with a
// final sign-fix cycle, and single-cycle fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [2:0]          op_q;
    logic                sign1_q;
    logic                sign2_q;
    logic [XLEN-1:0]     opnd_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;
    logic [XLEN-1:0]     result_q;

    logic                sign1;
    logic                sign2;
    logic [XLEN-1:0]     abs1;
    logic [XLEN-1:0]     abs2;
    logic                div_zero;
    logic                div_ovf;
    logic                special;
    logic [XLEN-1:0]     special_val;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       rem_trial;
    logic [XLEN:0]       rem_diff;
    logic [2*XLEN-1:0]   acc_step;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo;
    logic [XLEN-1:0]     rmd;
    logic [XLEN-1:0]     fix_val;

    // Request decode: operand signedness, magnitudes and the architecturally fixed results.
    always_comb begin
        sign1 = 1'b0;
        sign2 = 1'b0;
        unique case (bus.op)
            3'b001, 3'b100, 3'b110: begin
                sign1 = bus.operand1[XLEN-1];
                sign2 = bus.operand2[XLEN-1];
            end
            3'b010:  sign1 = bus.operand1[XLEN-1];
            default: ;
        endcase
        abs1 = sign1 ? -bus.operand1 : bus.operand1;
        abs2 = sign2 ? -bus.operand2 : bus.operand2;

        div_zero    = (bus.operand2 == '0);
        div_ovf     = !bus.op[0] && (bus.operand1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (bus.operand2 == '1);
        special     = bus.op[2] && (div_zero || div_ovf);
        special_val = '0;
        if (div_zero) begin
            special_val = bus.op[1] ? bus.operand1 : '1;
        end else begin
            special_val = bus.op[1] ? '0 : bus.operand1;
        end
    end

    // One iteration. Multiply: acc = {partial, multiplier}, shifted right.
    // Divide: acc = {remainder, dividend->quotient}, shifted left.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff  = rem_trial - {1'b0, opnd_q};
        acc_step  = '0;
        if (!op_q[2]) begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end else if (!rem_diff[XLEN]) begin
            acc_step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {rem_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and result selection.
    always_comb begin
        prod = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
        quo  = (sign1_q ^ sign2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rmd  = sign1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        unique case (op_q)
            3'b000:                 fix_val = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quo;
            default:                fix_val = rmd;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start && !bus.flush) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (special) begin
                            result_q <= special_val;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            op_q    <= bus.op;
                            sign1_q <= sign1;
                            sign2_q <= sign2;
                            cnt_q   <= '0;
                            // Multiplicand or divisor stays put; the other operand seeds acc.
                            if (bus.op[2]) begin
                                opnd_q <= abs2;
                                acc_q  <= {{XLEN{1'b0}}, abs1};
                            end else begin
                                opnd_q <= abs1;
                                acc_q  <= {{XLEN{1'b0}}, abs2};
                            end
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (bus.flush) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == CntW'(XLEN - 1)) begin
                            state_q <= StFix;
                        end
                    end
                end
                StFix: begin
                    if (bus.flush) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        result_q <= fix_val;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at XLEN=32 and XLEN=64: directed table, multi-cycle corner sequences
// and random operations checked against a wide-arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    bit          sel = 1'b0;  // 0 targets the 32-bit instance, 1 the 64-bit one
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        ready, busy, done;
    logic [63:0] result;

    int vectors = 0;
    int miscompares = 0;

    muldiv_unit_if #(.XLEN(32)) if32();
    muldiv_unit_if #(.XLEN(64)) if64();

    assign if32.start    = start & ~sel;
    assign if32.flush    = flush & ~sel;
    assign if32.op       = op;
    assign if32.operand1 = a[31:0];
    assign if32.operand2 = b[31:0];
    assign if64.start    = start & sel;
    assign if64.flush    = flush & sel;
    assign if64.op       = op;
    assign if64.operand1 = a;
    assign if64.operand2 = b;

    assign ready  = sel ? if64.ready : if32.ready;
    assign busy   = sel ? if64.busy  : if32.busy;
    assign done   = sel ? if64.done  : if32.done;
    assign result = sel ? if64.result : {32'b0, if32.result};

    muldiv_unit #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    muldiv_unit #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

    always #5 clk = ~clk;

    // Continuous protocol watch: ready/busy exclusive, done never two cycles in a row.
    logic prev_done32 = 1'b0;
    logic prev_done64 = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if ((if32.ready && if32.busy) || (if64.ready && if64.busy)) begin
                miscompares++;
                $display("FAIL ready_busy_exclusive: ready and busy both high at %0t", $time);
            end
            if ((if32.done && prev_done32) || (if64.done && prev_done64)) begin
                miscompares++;
                $display("FAIL done_one_cycle: done high for two cycles at %0t", $time);
            end
        end
        prev_done32 = if32.done;
        prev_done64 = if64.done;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: exact two's-complement arithmetic on 130-bit values, then truncated to XLEN.
    function automatic logic [63:0] ref_model(input bit w64, input logic [2:0] o,
                                              input logic [63:0] x, input logic [63:0] y);
        int                  w;
        logic [63:0]         mask;
        logic signed [129:0] ua, ub, sa, sb, p;
        w    = w64 ? 64 : 32;
        mask = w64 ? '1 : 64'h0000_0000_FFFF_FFFF;
        ua   = {66'b0, x & mask};
        ub   = {66'b0, y & mask};
        sa   = x[w-1] ? ua - (130'd1 << w) : ua;
        sb   = y[w-1] ? ub - (130'd1 << w) : ub;
        p    = '0;
        case (o)
            3'b000: p = ua * ub;
            3'b001: p = (sa * sb) >>> w;
            3'b010: p = (sa * ub) >>> w;
            3'b011: p = (ua * ub) >>> w;
            3'b100: p = (ub == 0) ? ua - ua - 1 : sa / sb;
            3'b101: p = (ub == 0) ? ua - ua - 1 : ua / ub;
            3'b110: p = (ub == 0) ? ua : sa % sb;
            default: p = (ub == 0) ? ua : ua % ub;
        endcase
        return p[63:0] & mask;
    endfunction

    function automatic int ref_latency(input bit w64, input logic [2:0] o,
                                       input logic [63:0] x, input logic [63:0] y);
        logic [63:0] mask, smin;
        mask = w64 ? '1 : 64'h0000_0000_FFFF_FFFF;
        smin = w64 ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        if (o[2] && (((y & mask) == 0) ||
                     (!o[0] && ((x & mask) == smin) && ((y & mask) == mask)))) return 1;
        return w64 ? 66 : 34;
    endfunction

    function automatic logic [63:0] rnd_opnd(input bit w64);
        logic [63:0] v;
        int          k;
        k = $urandom_range(0, 9);
        if (k == 0)      v = '0;
        else if (k == 1) v = '1;
        else if (k == 2) v = w64 ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        else if (k == 3) v = 64'($urandom_range(1, 20));
        else             v = {$urandom, $urandom};
        if (!w64) v[63:32] = '0;
        return v;
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check({name, " ready timeout"}, {63'b0, ready}, 64'd1);
    endtask

    // Issue one request, wait for done (bounded), check result, latency and ready return.
    task automatic run_check(input string name, input bit w64, input logic [2:0] o,
                             input logic [63:0] x, input logic [63:0] y,
                             input logic [63:0] exp, input int exp_lat);
        int          lat;
        bit          got;
        logic [63:0] res;
        sel = w64;
        wait_ready(name);
        op = o; a = x; b = y; start = 1'b1;
        lat = 0; got = 1'b0; res = '0;
        while (!got && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (done) begin
                got = 1'b1;
                res = result;
            end
        end
        check({name, " result"}, res, exp);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
        check({name, " ready after done"}, {63'b0, ready}, 64'd1);
    endtask

    typedef struct {
        string       name;
        bit          w64;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl [20];

    initial begin
        int          lat;
        bit          saw_done;
        logic [63:0] x, y, exp;
        logic [2:0]  o;

        tbl[0]  = '{"mul_7_m3",        0, 3'b000, 64'h7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 34};
        tbl[1]  = '{"mulhu_7_m3",      0, 3'b011, 64'h7, 64'hFFFF_FFFD, 64'h6, 34};
        tbl[2]  = '{"mulh_min_min",    0, 3'b001, 64'h8000_0000, 64'h8000_0000,
                    64'h4000_0000, 34};
        tbl[3]  = '{"mulhsu_m1_m1",    0, 3'b010, 64'hFFFF_FFFF, 64'hFFFF_FFFF,
                    64'hFFFF_FFFF, 34};
        tbl[4]  = '{"mul_min_min",     0, 3'b000, 64'h8000_0000, 64'h8000_0000, 64'h0, 34};
        tbl[5]  = '{"div_m7_2",        0, 3'b100, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD, 34};
        tbl[6]  = '{"rem_m7_2",        0, 3'b110, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFF, 34};
        tbl[7]  = '{"divu_m7_2",       0, 3'b101, 64'hFFFF_FFF9, 64'h2, 64'h7FFF_FFFC, 34};
        tbl[8]  = '{"remu_m7_2",       0, 3'b111, 64'hFFFF_FFF9, 64'h2, 64'h1, 34};
        tbl[9]  = '{"divu_by_zero",    0, 3'b101, 64'h1234, 64'h0, 64'hFFFF_FFFF, 1};
        tbl[10] = '{"rem_by_zero",     0, 3'b110, 64'h1234, 64'h0, 64'h1234, 1};
        tbl[11] = '{"div_overflow",    0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF,
                    64'h8000_0000, 1};
        tbl[12] = '{"rem_overflow",    0, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 1};
        tbl[13] = '{"mulh_m1_3",       0, 3'b001, 64'hFFFF_FFFF, 64'h3, 64'hFFFF_FFFF, 34};
        tbl[14] = '{"rem_7_m2",        0, 3'b110, 64'h7, 64'hFFFF_FFFE, 64'h1, 34};
        tbl[15] = '{"mulh64_min_min",  1, 3'b001, 64'h8000_0000_0000_0000,
                    64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 66};
        tbl[16] = '{"div64_m7_2",      1, 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2,
                    64'hFFFF_FFFF_FFFF_FFFD, 66};
        tbl[17] = '{"divu64_by_zero",  1, 3'b101, 64'h55, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        tbl[18] = '{"div64_overflow",  1, 3'b100, 64'h8000_0000_0000_0000,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        tbl[19] = '{"remu64_100_7",    1, 3'b111, 64'd100, 64'd7, 64'd2, 66};

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            check("reset ready",  {63'b0, ready}, 64'd1);
            check("reset busy",   {63'b0, busy},  64'd0);
            check("reset done",   {63'b0, done},  64'd0);
            check("reset result", result, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_check(tbl[i].name, tbl[i].w64, tbl[i].op, tbl[i].a, tbl[i].b,
                      tbl[i].exp, tbl[i].lat);
        end

        // Flush on the 10th CALC cycle: no done, idle next cycle, result unchanged.
        run_check("divu_prep", 0, 3'b101, 64'd100, 64'd7, 64'd14, 34);
        sel = 1'b0;
        wait_ready("flush_div");
        op = 3'b100; a = 64'd1000; b = 64'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush ready", {63'b0, ready}, 64'd1);
        check("flush busy",  {63'b0, busy},  64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("flush no done", {63'b0, saw_done}, 64'd0);
        check("flush result kept", result, 64'd14);

        // Flush together with start in IDLE drops the request.
        @(negedge clk);
        op = 3'b101; a = 64'h99; b = 64'h0; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start busy", {63'b0, busy}, 64'd0);
        @(posedge clk); #1;
        check("flush_start done", {63'b0, done}, 64'd0);
        check("flush_start result", result, 64'd14);

        // A start pulse mid-CALC is ignored.
        wait_ready("busy_start");
        x = 64'h1234_5678; y = 64'h9ABC_DEF0;
        op = 3'b011; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (5) begin
            @(posedge clk); #1;
            lat++;
        end
        op = 3'b000; a = 64'd5; b = 64'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy_start result", result, ref_model(0, 3'b011, x, y));
        check("busy_start latency", 64'(lat), 64'd34);

        // Asynchronous reset mid-CALC clears outputs without waiting for a clock edge.
        wait_ready("async_rst");
        op = 3'b000; a = 64'd3; b = 64'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst busy",   {63'b0, busy},  64'd0);
        check("async_rst done",   {63'b0, done},  64'd0);
        check("async_rst ready",  {63'b0, ready}, 64'd1);
        check("async_rst result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random operations at both widths against the reference model.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 50; i++) begin
                o   = 3'($urandom_range(0, 7));
                x   = rnd_opnd(s == 1);
                y   = rnd_opnd(s == 1);
                exp = ref_model(s == 1, o, x, y);
                run_check($sformatf("rand%0d_%0d op%0d", (s == 1) ? 64 : 32, i, o),
                          (s == 1), o, x, y, exp, ref_latency(s == 1, o, x, y));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
